// File: rtl/noc_pkg.sv
// noc_pkg: shared constants for the mesh router input port.
//   FLIT_W          flit width (dest X, dest Y, payload)
//   DEST_*          dest coordinate bit positions inside a flit
//   port_idx_e      output-port indices PORT_N..PORT_L
//   ROUTE_*         one-hot route encodings {L,W,E,S,N} = bits [4:0]
//   DEFAULT_DEPTH   default flit buffer depth (= sender's initial credits)
//   xy_route()      dimension-ordered (X then Y) route computation
package noc_pkg;

  localparam int FLIT_W        = 20;
  localparam int COORD_W       = 2;
  localparam int PAYLOAD_W     = 16;
  localparam int DEST_X_HI     = 19;
  localparam int DEST_X_LO     = 18;
  localparam int DEST_Y_HI     = 17;
  localparam int DEST_Y_LO     = 16;
  localparam int ROUTE_W       = 5;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum int unsigned {
    PORT_N = 0,
    PORT_S = 1,
    PORT_E = 2,
    PORT_W = 3,
    PORT_L = 4
  } port_idx_e;

  localparam logic [ROUTE_W-1:0] ROUTE_NONE = '0;
  localparam logic [ROUTE_W-1:0] ROUTE_N    = ROUTE_W'(1) << PORT_N;
  localparam logic [ROUTE_W-1:0] ROUTE_S    = ROUTE_W'(1) << PORT_S;
  localparam logic [ROUTE_W-1:0] ROUTE_E    = ROUTE_W'(1) << PORT_E;
  localparam logic [ROUTE_W-1:0] ROUTE_W_   = ROUTE_W'(1) << PORT_W;
  localparam logic [ROUTE_W-1:0] ROUTE_L    = ROUTE_W'(1) << PORT_L;

  // X is resolved first, Y only once the flit is in the right column.
  function automatic logic [ROUTE_W-1:0] xy_route(
    input logic [COORD_W-1:0] dest_x,
    input logic [COORD_W-1:0] dest_y,
    input logic [COORD_W-1:0] here_x,
    input logic [COORD_W-1:0] here_y
  );
    logic [ROUTE_W-1:0] r;
    if (dest_x > here_x)      r = ROUTE_E;
    else if (dest_x < here_x) r = ROUTE_W_;
    else if (dest_y > here_y) r = ROUTE_N;
    else if (dest_y < here_y) r = ROUTE_S;
    else                      r = ROUTE_L;
    return r;
  endfunction

endpackage

// File: rtl/router_in_port_fifo.sv
// flit_fifo: DEPTH-entry circular flit buffer for router_in_port.
//   clk, rst      clock, synchronous active-high reset (clears pointers/count)
//   push          write wdata this edge (caller guarantees space or same-edge pop)
//   pop           advance read pointer this edge (caller guarantees non-empty)
//   wdata         flit to store
//   rdata         entry at rd_ptr
//   full, empty   count == DEPTH / count == 0
// DEPTH must be at least 2.
module flit_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = FLIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; entries are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/router_in_port.sv
// router_in_port: mesh router input port -- flit buffer, XY route compute,
// credit return to the upstream sender.
//   clk        clock
//   RST        synchronous active-high reset
//   datain     incoming flit {dest X[19:18], dest Y[17:16], payload[15:0]}
//   in_valid   datain carries a flit
//   co         one-cycle credit pulse, the cycle after each pop
//   dataout    head-of-buffer flit
//   out_valid  buffer non-empty
//   route      one-hot {L,W,E,S,N} request for the head flit, 0 when empty
//   out_ready  switch grant; pop on out_valid && out_ready
//   err_ovf    sticky dropped-flit flag
// Optional feature: define ROUTER_IN_PORT_OVF_DETECT_EN to enable err_ovf;
// otherwise it is tied low (flits are still dropped when full).
module router_in_port
  import noc_pkg::*;
#(
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int DEPTH    = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [FLIT_W-1:0]  datain,
  input  logic               in_valid,
  output logic               co,
  output logic [FLIT_W-1:0]  dataout,
  output logic               out_valid,
  output logic [ROUTE_W-1:0] route,
  input  logic               out_ready,
  output logic               err_ovf
);

  localparam logic [COORD_W-1:0] HERE_X = COORD_W'(ROUTER_X);
  localparam logic [COORD_W-1:0] HERE_Y = COORD_W'(ROUTER_Y);

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts a flit when the head leaves on the same edge.
  assign push      = in_valid && (!full || pop);

  flit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (datain),
    .rdata (dataout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    route = ROUTE_NONE;
    if (out_valid)
      route = xy_route(dataout[DEST_X_HI:DEST_X_LO], dataout[DEST_Y_HI:DEST_Y_LO],
                       HERE_X, HERE_Y);
  end

  always_ff @(posedge clk) begin
    if (RST) co <= 1'b0;
    else     co <= pop;
  end

`ifdef ROUTER_IN_PORT_OVF_DETECT_EN
  logic drop;
  assign drop = in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (RST)       err_ovf <= 1'b0;
    else if (drop) err_ovf <= 1'b1;
  end
`else
  assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_router_in_port.sv
module tb_router_in_port;
  import noc_pkg::*;

`ifdef ROUTER_IN_PORT_OVF_DETECT_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_E = 5'b00100;
  localparam logic [4:0] R_W = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;
  localparam logic [4:0] R_0 = 5'b00000;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [19:0] datain = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        co;
  logic [19:0] dataout;
  logic        out_valid;
  logic [4:0]  route;
  logic        err_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  router_in_port #(
    .ROUTER_X (1),
    .ROUTER_Y (1),
    .DEPTH    (4)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .datain    (datain),
    .in_valid  (in_valid),
    .co        (co),
    .dataout   (dataout),
    .out_valid (out_valid),
    .route     (route),
    .out_ready (out_ready),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [19:0] d;
    logic        rdy;
    logic        e_valid;
    logic [19:0] e_data;
    logic [4:0]  e_route;
    logic        e_co;
    logic        e_err;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [19:0] d, input logic rdy, input logic rs);
    @(negedge clk);
    in_valid  = v;
    datain    = d;
    out_ready = rdy;
    RST       = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [19:0] ed,
                         input logic [4:0] er, input logic eco, input logic eerr);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    if (ev) chk({tag, ".dataout"}, 32'(dataout), 32'(ed));
    chk({tag, ".route"}, 32'(route), 32'(er));
    chk({tag, ".co"}, 32'(co), 32'(eco));
    chk({tag, ".err_ovf"}, 32'(err_ovf), 32'(eerr));
  endtask

  initial begin
    logic O;
    O = OVF_EXP;
    //          v  data        rdy  ev  edata      route co err
    vecs[0]  = '{1, 20'h3_1234, 0,  1, 20'h3_1234, R_W, 0, 0};
    vecs[1]  = '{1, 20'h5_0001, 0,  1, 20'h3_1234, R_W, 0, 0};
    vecs[2]  = '{1, 20'h7_0002, 0,  1, 20'h3_1234, R_W, 0, 0};
    vecs[3]  = '{1, 20'h9_0003, 0,  1, 20'h3_1234, R_W, 0, 0};
    vecs[4]  = '{1, 20'hF_0004, 0,  1, 20'h3_1234, R_W, 0, O};
    vecs[5]  = '{0, 20'h0_0000, 1,  1, 20'h5_0001, R_L, 1, O};
    vecs[6]  = '{0, 20'h0_0000, 1,  1, 20'h7_0002, R_N, 1, O};
    vecs[7]  = '{0, 20'h0_0000, 1,  1, 20'h9_0003, R_E, 1, O};
    vecs[8]  = '{0, 20'h0_0000, 1,  0, 20'h0_0000, R_0, 1, O};
    vecs[9]  = '{0, 20'h0_0000, 0,  0, 20'h0_0000, R_0, 0, O};
    vecs[10] = '{1, 20'h4_0010, 0,  1, 20'h4_0010, R_S, 0, O};
    vecs[11] = '{1, 20'h8_0011, 0,  1, 20'h4_0010, R_S, 0, O};
    vecs[12] = '{1, 20'h0_0012, 1,  1, 20'h8_0011, R_E, 1, O};
    vecs[13] = '{1, 20'h6_0013, 1,  1, 20'h0_0012, R_W, 1, O};
    vecs[14] = '{1, 20'h5_0014, 1,  1, 20'h6_0013, R_N, 1, O};
    vecs[15] = '{0, 20'h0_0000, 1,  1, 20'h5_0014, R_L, 1, O};
    vecs[16] = '{0, 20'h0_0000, 1,  0, 20'h0_0000, R_0, 1, O};
    vecs[17] = '{0, 20'h0_0000, 1,  0, 20'h0_0000, R_0, 0, O};
    vecs[18] = '{1, 20'h1_0020, 1,  1, 20'h1_0020, R_W, 0, O};
    vecs[19] = '{0, 20'h0_0000, 0,  1, 20'h1_0020, R_W, 0, O};

    // Reset state
    step(1'b0, 20'h0, 1'b0, 1'b1);
    step(1'b0, 20'h0, 1'b0, 1'b1);
    chk_all("reset", 1'b0, 20'h0, R_0, 1'b0, 1'b0);

    // Table-driven main function
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].rdy, 1'b0);
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
              vecs[i].e_route, vecs[i].e_co, vecs[i].e_err);
    end

    // Mid-operation reset with 3 flits buffered, push/pop requested in reset cycle
    step(1'b1, 20'h5_0030, 1'b0, 1'b0);
    step(1'b1, 20'h5_0031, 1'b0, 1'b0);
    chk_all("pre_rst", 1'b1, 20'h1_0020, R_W, 1'b0, OVF_EXP);
    step(1'b1, 20'h5_0032, 1'b1, 1'b1);
    chk_all("rst_mid", 1'b0, 20'h0, R_0, 1'b0, 1'b0);
    step(1'b0, 20'h0, 1'b1, 1'b0);
    chk_all("post_rst", 1'b0, 20'h0, R_0, 1'b0, 1'b0);

    // Full buffer accepts a flit when the head pops on the same edge
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 20'h5_0100 + 20'(i), 1'b0, 1'b0);
      chk_all($sformatf("fill%0d", i), 1'b1, 20'h5_0100, R_L, 1'b0, 1'b0);
    end
    step(1'b1, 20'h5_0104, 1'b1, 1'b0);
    chk_all("full_pushpop", 1'b1, 20'h5_0101, R_L, 1'b1, 1'b0);
    for (int i = 2; i < 5; i++) begin
      step(1'b0, 20'h0, 1'b1, 1'b0);
      chk_all($sformatf("drain%0d", i), 1'b1, 20'h5_0100 + 20'(i), R_L, 1'b1, 1'b0);
    end
    step(1'b0, 20'h0, 1'b1, 1'b0);
    chk_all("drain_last", 1'b0, 20'h0, R_0, 1'b1, 1'b0);
    step(1'b0, 20'h0, 1'b0, 1'b0);
    chk_all("idle_end", 1'b0, 20'h0, R_0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_in_port.md
ROUTER_IN_PORT -- requirements
Module: router_in_port

Interface
REQ-001 Parameter ROUTER_X, default 0, mesh X coordinate of the owning router (0-3).
REQ-002 Parameter ROUTER_Y, default 0, mesh Y coordinate of the owning router (0-3).
REQ-003 Parameter DEPTH, default 4, flit buffer entries; SHALL equal the sender's initial credit count.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 datain  input  20  incoming flit; [19:18] dest X, [17:16] dest Y, [15:0] payload.
REQ-007 in_valid  input  1  datain carries a flit this cycle.
REQ-008 co  output  1  credit-out pulse to the upstream sender, one per flit freed.
REQ-009 dataout  output  20  head-of-buffer flit.
REQ-010 out_valid  output  1  buffer non-empty; dataout and route valid.
REQ-011 route  output  5  one-hot output-port request {L,W,E,S,N} = bits [4:0] for the head flit.
REQ-012 out_ready  input  1  switch grant; a flit is popped when out_valid && out_ready.
REQ-013 err_ovf  output  1  sticky overflow flag (see Configuration).

Function
REQ-014 Buffer SHALL be a DEPTH-entry circular FIFO with wr_ptr, rd_ptr and count of width clog2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
REQ-015 A flit with in_valid=1 SHALL be written at the rising edge when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-016 A written flit SHALL appear on dataout with out_valid=1 in the cycle after the write edge (1-cycle latency) when the buffer was empty.
REQ-017 out_valid SHALL equal (count!=0); dataout SHALL be the entry at rd_ptr; dataout is don't-care but stable when out_valid=0.
REQ-018 Pop SHALL occur only when out_valid && out_ready; out_ready with out_valid=0 SHALL have no effect.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 co SHALL be a registered signal, high for exactly one cycle in the cycle after each pop edge; back-to-back pops give consecutive co cycles.
REQ-021 route SHALL be combinational from dataout: destX>ROUTER_X -> E; destX<ROUTER_X -> W; else destY>ROUTER_Y -> N; destY<ROUTER_Y -> S; else L (XY routing).
REQ-022 route SHALL be 5'b0 when out_valid=0.
REQ-023 in_valid when full without a same-cycle pop SHALL drop the flit and leave buffer contents, pointers and count unchanged.

Reset
REQ-024 RST=1 at a rising edge SHALL clear wr_ptr, rd_ptr, count, co and err_ovf to 0; out_valid=0, route=0 follow.
REQ-025 Reset mid-operation SHALL discard all buffered flits and SHALL NOT emit co for them; upstream is reset concurrently.
REQ-026 Push and pop requests in a reset cycle SHALL be ignored.

Configuration
REQ-027 Macro ROUTER_IN_PORT_OVF_DETECT_EN defined: err_ovf SHALL set on the edge of any dropped flit (REQ-023) and hold until RST.
REQ-028 Macro undefined: err_ovf SHALL be tied to 0 and no detection logic compiled; drop behaviour of REQ-023 is unchanged.

Structure
REQ-029 Package noc_pkg SHALL hold FLIT_W=20, dest-field bit positions, port index constants (PORT_N..PORT_L), one-hot route encodings and default DEPTH.
REQ-030 Storage SHALL be a sub-module flit_fifo (pointers, count, memory); route compute and credit return stay in router_in_port.

Verification
REQ-031 ROUTER_X=1,ROUTER_Y=1; push flit 20'h3_1234 (dest 0,3) to empty buffer -> out_valid=1 next cycle, route=W (5'b01000).
REQ-032 Push 4 flits with out_ready=0 -> count=4; push 5th -> dropped, err_ovf=1 (macro on) / 0 (macro off), first 4 intact in order.
REQ-033 Full buffer, out_ready=1 for 4 cycles -> 4 pops in FIFO order, co high 4 consecutive cycles each one cycle after its pop, out_valid=0 after last.
REQ-034 Count=2, in_valid=1 and out_ready=1 same cycle -> count stays 2, one co pulse, ordering preserved across pointer wrap.
REQ-035 Dest equal to (ROUTER_X,ROUTER_Y) -> route=L (5'b10000); dest (1,3) at router (1,1) -> route=N (5'b00001).
REQ-036 RST=1 with 3 flits buffered -> next cycle out_valid=0, co=0, err_ovf=0, no co pulses for discarded flits.
